sram_port_arb: RTL and testbench
================================

# sram_port_arb

Two-requester arbiter and sequencer for the 128-bit, 16-byte-lane single-port program/data SRAM behind the AXI slave. Port 0 is the AXI slave memory path. Port 1 is a secondary master: the program loader or a debug/backdoor engine. The block grants one beat per cycle using round-robin, locks the grant for multi-beat bursts, and bounds each lock so neither port starves. It returns read data to the port that issued the read.

## Interface
Parameters:
- ADDR_W, 20, SRAM word (16-byte) address width
- MAX_LOCK, 16, maximum consecutive beats one port may hold a lock while the other port is requesting

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-high reset
- p0_req_valid / p1_req_valid  in  1  beat request
- p0_req_ready / p1_req_ready  out  1  beat accepted this cycle
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_addr / p1_req_addr  in  ADDR_W  word address
- p0_req_wdata / p1_req_wdata  in  128  write data; lane k is bits [8k+7:8k]
- p0_req_wstrb / p1_req_wstrb  in  16  byte-lane write enables
- p0_req_last / p1_req_last  in  1  final beat of a burst; 0 requests a lock
- p0_rsp_valid / p1_rsp_valid  out  1  read data valid
- p0_rsp_rdata / p1_rsp_rdata  out  128  read data
- mem_en  out  1  SRAM access strobe
- mem_we  out  16  per-lane write enable, active high
- mem_addr  out  ADDR_W  SRAM address
- mem_din  out  128  SRAM write data
- mem_dout  in  128  SRAM read data, valid exactly 1 cycle after mem_en with mem_we = 0

## Operation
- **FSM states:** IDLE, LOCK0, LOCK1. Registers: rr_ptr (port that wins the next tie), lock_cnt (width is clog2(MAX_LOCK)+1), rd_pend (valid bit plus port id).
- **IDLE, one port valid:** that port is granted.
- **IDLE, both ports valid:** the port named by rr_ptr is granted.
- **Lock entry:** if the granted beat has last = 0, go to LOCKn and set lock_cnt = 1.
- **After every granted beat that ends a grant:** rr_ptr becomes the other port. In IDLE this is any beat with last = 1. In a lock it is the beat that leaves LOCKn.
- **LOCKn behaviour:** only port n is granted, so the other port's ready = 0. Each beat accepted from port n increments lock_cnt.
- **Leaving LOCKn, normal:** an accepted beat with last = 1 returns to IDLE.
- **Leaving LOCKn, forced release:** if lock_cnt == MAX_LOCK and the other port is valid, force IDLE. rr_ptr goes to the other port. Port n must re-arbitrate to continue; its burst resumes from the next beat.
- **LOCKn with port n idle:** if port n is not valid, stay in LOCKn. No beat is issued.
- **Grant datapath:** mem_en = 1. mem_addr and mem_din come from the granted port. mem_we = wstrb when we = 1, else 0.
- **Write with wstrb = 0:** the write still consumes a slot and drives mem_en. It writes nothing.
- **Reads:** rd_pend records the issuing port. Next cycle, that port's rsp_valid = 1 and rsp_rdata = mem_dout.
- **Writes:** no response.
- **rsp_rdata when rsp_valid = 0:** don't-care; it is driven to 0.

## Timing
- **Reset values:** FSM = IDLE, rr_ptr = 0, lock_cnt = 0, rd_pend = 0, all ready = 0, rsp_valid = 0, mem_en = 0, mem_we = 0.
- **Grant path:** ready and mem_* are combinational from the current state and the valid inputs. A beat is accepted in the cycle where valid and ready are both 1.
- **Read latency:** 1 cycle from acceptance to rsp_valid. A read may be accepted every cycle, with back-to-back responses.
- **Throughput:** at most one beat per cycle across both ports. There are no idle cycles on handover.
- **Reset asserted mid-burst:** on the next edge the FSM is IDLE and rd_pend is cleared. A read accepted in the reset cycle produces no response.
- **valid dropped mid-lock:** the lock holds indefinitely. The other port is blocked unless lock_cnt == MAX_LOCK.

## Structure
- Package sram_arb_pkg holds:
  - the state enum (IDLE/LOCK0/LOCK1)
  - the data width (128) and lane count (16)
  - a request struct {we, addr, wdata, wstrb, last}
- Sub-module sram_arb_rr: a 2-way round-robin picker that outputs a grant index and updates the pointer. It is reused for port counts above 2 later.
- The rd_pend tracking and the response demux stay in the top module.

## Test plan
- **Single read:** p0 reads addr 0x00010, with the SRAM preloaded to 0x0123..EF. Expect mem_en in cycle N, then p0_rsp_valid and the data in cycle N+1. p1_rsp_valid stays 0.
- **Tie:** both ports are valid with last = 1, after reset. The grant order is p0, p1, p0, p1 over 4 cycles, with ready alternating.
- **Burst lock:** p1 sends 4 beats (last on beat 4) while p0 is continuously valid. Expect 4 consecutive p1 grants, then p0 is granted.
- **Starvation bound:** p0 sends an endless burst (last = 0) with MAX_LOCK = 16, and p1 is valid. Expect p1 to be granted in cycle 17 of the lock, then p0 to resume.
- **Partial write:** p1 writes wstrb = 16'h00F0 with wdata = 0x...DEADBEEF_00000000 to addr 0x1FFFF. Expect mem_we = 0x00F0, and a read-back changes only lanes 4–7.
- **Reset mid-burst:** assert rst during the 3rd beat of a p0 read burst. No rsp_valid follows. The FSM is IDLE, and the next p1 request is granted immediately.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, datapath geometry
// and the per-port beat request bundle.
package sram_arb_pkg;

   localparam int DATA_W  = 128;
   localparam int LANES   = 16;
   // The request bundle carries the widest supported word address; ADDR_W <= SRAM_AW.
   localparam int SRAM_AW = 20;

   typedef enum logic [1:0] {
      IDLE,
      LOCK0,
      LOCK1
   } state_e;

   typedef struct packed {
      logic               we;
      logic [SRAM_AW-1:0] addr;
      logic [DATA_W-1:0]  wdata;
      logic [LANES-1:0]   wstrb;
      logic               last;
   } req_t;

endpackage

// File: rtl/sram_arb_rr.sv
// N-way round-robin picker: first requester at or after ptr wins, ptr_nxt names
// the port just past the winner.
module sram_arb_rr #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_vld,
   output logic [IW-1:0] gnt_idx,
   output logic [IW-1:0] ptr_nxt
);

   always_comb begin
      int c;
      c       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      ptr_nxt = ptr;
      // Walk the offsets from farthest to nearest so the nearest requester sticks.
      for (int i = N - 1; i >= 0; i--) begin
         c = (int'(ptr) + i) % N;
         if (req[c[IW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = c[IW-1:0];
            ptr_nxt = (c == N - 1) ? '0 : IW'(c + 1);
         end
      end
   end

endmodule

// File: rtl/sram_port_arb.sv
// Two-port arbiter/sequencer for the 128-bit single-port SRAM: round-robin
// per beat, burst locking with a starvation bound, and read-response routing.
module sram_port_arb
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W   = 20,
   parameter int MAX_LOCK = 16
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                p0_req_valid,
   output logic                p0_req_ready,
   input  logic                p0_req_we,
   input  logic [ADDR_W-1:0]   p0_req_addr,
   input  logic [DATA_W-1:0]   p0_req_wdata,
   input  logic [LANES-1:0]    p0_req_wstrb,
   input  logic                p0_req_last,
   output logic                p0_rsp_valid,
   output logic [DATA_W-1:0]   p0_rsp_rdata,

   input  logic                p1_req_valid,
   output logic                p1_req_ready,
   input  logic                p1_req_we,
   input  logic [ADDR_W-1:0]   p1_req_addr,
   input  logic [DATA_W-1:0]   p1_req_wdata,
   input  logic [LANES-1:0]    p1_req_wstrb,
   input  logic                p1_req_last,
   output logic                p1_rsp_valid,
   output logic [DATA_W-1:0]   p1_rsp_rdata,

   output logic                mem_en,
   output logic [LANES-1:0]    mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_din,
   input  logic [DATA_W-1:0]   mem_dout
);

   localparam int CNT_W = $clog2(MAX_LOCK) + 1;

   state_e           state;
   logic             rr_ptr;
   logic [CNT_W-1:0] lock_cnt;
   logic             rd_vld;
   logic             rd_port;

   req_t [1:0]       req;
   logic [1:0]       vld;

   logic             in_lock, lock_n, at_max, force_rel, arb_mode, pick_ptr;
   logic             rr_vld, rr_idx, rr_ptr_nxt;
   logic             gnt, gnt_idx;
   req_t             sel;

   assign req[0] = '{we: p0_req_we, addr: SRAM_AW'(p0_req_addr), wdata: p0_req_wdata,
                     wstrb: p0_req_wstrb, last: p0_req_last};
   assign req[1] = '{we: p1_req_we, addr: SRAM_AW'(p1_req_addr), wdata: p1_req_wdata,
                     wstrb: p1_req_wstrb, last: p1_req_last};
   assign vld    = {p1_req_valid, p0_req_valid};

   // A lock that has hit its bound while the other port waits behaves like IDLE
   // with the tie going to the waiting port, so the handover costs no cycle.
   assign in_lock   = (state != IDLE);
   assign lock_n    = (state == LOCK1);
   assign at_max    = (lock_cnt == CNT_W'(MAX_LOCK));
   assign force_rel = in_lock && at_max && vld[!lock_n];
   assign arb_mode  = !in_lock || force_rel;
   assign pick_ptr  = force_rel ? !lock_n : rr_ptr;

   sram_arb_rr #(.N(2)) u_rr (
      .req     (vld),
      .ptr     (pick_ptr),
      .gnt_vld (rr_vld),
      .gnt_idx (rr_idx),
      .ptr_nxt (rr_ptr_nxt)
   );

   assign gnt     = arb_mode ? rr_vld : vld[lock_n];
   assign gnt_idx = arb_mode ? rr_idx : lock_n;
   assign sel     = req[gnt_idx];

   assign p0_req_ready = gnt && !gnt_idx;
   assign p1_req_ready = gnt &&  gnt_idx;

   assign mem_en   = gnt;
   assign mem_we   = (gnt && sel.we) ? sel.wstrb : '0;
   assign mem_addr = gnt ? sel.addr[ADDR_W-1:0] : '0;
   assign mem_din  = gnt ? sel.wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= 1'b0;
         lock_cnt <= '0;
         rd_vld   <= 1'b0;
         rd_port  <= 1'b0;
      end else begin
         rd_vld  <= gnt && !sel.we;
         rd_port <= gnt_idx;
         if (gnt) begin
            if (sel.last) begin
               state    <= IDLE;
               lock_cnt <= '0;
               rr_ptr   <= arb_mode ? rr_ptr_nxt : !lock_n;
            end else if (arb_mode) begin
               state    <= gnt_idx ? LOCK1 : LOCK0;
               lock_cnt <= CNT_W'(1);
               if (force_rel)
                  rr_ptr <= !lock_n;
            end else if (!at_max) begin
               lock_cnt <= lock_cnt + 1'b1;
            end
         end
      end
   end

   assign p0_rsp_valid = rd_vld && !rd_port;
   assign p1_rsp_valid = rd_vld &&  rd_port;
   assign p0_rsp_rdata = p0_rsp_valid ? mem_dout : '0;
   assign p1_rsp_rdata = p1_rsp_valid ? mem_dout : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with a small behavioural SRAM behind it.
module tb_sram_port_arb;

   localparam logic [127:0] PRE0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] PRE1 = 128'h00112233445566778899AABBCCDDEEFF;

   logic         clk = 1'b0;
   logic         rst;
   logic         p0_req_valid, p0_req_ready, p0_req_we, p0_req_last, p0_rsp_valid;
   logic [19:0]  p0_req_addr;
   logic [127:0] p0_req_wdata, p0_rsp_rdata;
   logic [15:0]  p0_req_wstrb;
   logic         p1_req_valid, p1_req_ready, p1_req_we, p1_req_last, p1_rsp_valid;
   logic [19:0]  p1_req_addr;
   logic [127:0] p1_req_wdata, p1_rsp_rdata;
   logic [15:0]  p1_req_wstrb;
   logic         mem_en;
   logic [15:0]  mem_we;
   logic [19:0]  mem_addr;
   logic [127:0] mem_din, mem_dout;

   logic [127:0] sram [0:4095];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sram_port_arb #(.ADDR_W(20), .MAX_LOCK(16)) dut (
      .clk(clk), .rst(rst),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
      .p0_req_last(p0_req_last), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
      .p1_req_last(p1_req_last), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   // SRAM model: 12-bit index, registered read, per-lane write; preloads under reset.
   always @(posedge clk) begin
      if (rst) begin
         sram[12'h010] <= PRE0;
         sram[12'hFFF] <= PRE1;
      end
      if (mem_en) begin
         if (mem_we == 16'h0)
            mem_dout <= sram[mem_addr[11:0]];
         for (int k = 0; k < 16; k++)
            if (mem_we[k])
               sram[mem_addr[11:0]][8*k +: 8] <= mem_din[8*k +: 8];
      end
   end

   task automatic chkb(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic v, input logic we, input logic [19:0] a,
                       input logic [127:0] d, input logic [15:0] s, input logic l);
      p0_req_valid = v; p0_req_we = we; p0_req_addr = a;
      p0_req_wdata = d; p0_req_wstrb = s; p0_req_last = l;
   endtask

   task automatic drv1(input logic v, input logic we, input logic [19:0] a,
                       input logic [127:0] d, input logic [15:0] s, input logic l);
      p1_req_valid = v; p1_req_we = we; p1_req_addr = a;
      p1_req_wdata = d; p1_req_wstrb = s; p1_req_last = l;
   endtask

   task automatic idle();
      drv0(1'b0, 1'b0, 20'h0, 128'h0, 16'h0, 1'b1);
      drv1(1'b0, 1'b0, 20'h0, 128'h0, 16'h0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [127:0] d;
      rst = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      #1;
      chkb("rst_p0_ready", p0_req_ready, 1'b0);
      chkb("rst_p1_ready", p1_req_ready, 1'b0);
      chkb("rst_mem_en",   mem_en,       1'b0);
      chkw("rst_mem_we",   128'(mem_we), 128'h0);
      chkb("rst_p0_rsp",   p0_rsp_valid, 1'b0);
      chkb("rst_p1_rsp",   p1_rsp_valid, 1'b0);
      rst = 1'b0;

      // single read
      @(negedge clk); drv0(1'b1, 1'b0, 20'h00010, 128'h0, 16'h0, 1'b1); #1;
      chkb("rd_p0_ready", p0_req_ready, 1'b1);
      chkb("rd_mem_en",   mem_en,       1'b1);
      chkw("rd_mem_we",   128'(mem_we), 128'h0);
      chkw("rd_mem_addr", 128'(mem_addr), 128'h10);
      @(negedge clk); idle(); #1;
      chkb("rd_p0_rsp",   p0_rsp_valid, 1'b1);
      chkw("rd_p0_data",  p0_rsp_rdata, PRE0);
      chkb("rd_p1_rsp",   p1_rsp_valid, 1'b0);
      chkw("rd_p1_data",  p1_rsp_rdata, 128'h0);
      chkb("rd_mem_en_off", mem_en, 1'b0);

      // tie after reset: alternate p0, p1
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drv0(1'b1, 1'b0, 20'h00100, 128'h0, 16'h0, 1'b1);
         drv1(1'b1, 1'b0, 20'h00200, 128'h0, 16'h0, 1'b1);
         #1;
         chkb("tie_p0_ready", p0_req_ready, 1'((i % 2) == 0));
         chkb("tie_p1_ready", p1_req_ready, 1'((i % 2) == 1));
         chkw("tie_mem_addr", 128'(mem_addr), ((i % 2) == 0) ? 128'h100 : 128'h200);
         chkb("tie_p0_rsp",   p0_rsp_valid, 1'((i % 2) == 1));
         chkb("tie_p1_rsp",   p1_rsp_valid, 1'(i >= 2 && (i % 2) == 0));
      end
      @(negedge clk); idle(); #1;
      chkb("tie_p1_rsp_last", p1_rsp_valid, 1'b1);

      // burst lock: one p0 beat moves the pointer to p1, then p1 locks for 4 beats
      @(negedge clk); drv0(1'b1, 1'b0, 20'h00010, 128'h0, 16'h0, 1'b1); #1;
      chkb("bl_pre_p0_ready", p0_req_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         d = {4{32'hA5A50000 + 32'(i)}};
         drv0(1'b1, 1'b0, 20'h00010, 128'h0, 16'h0, 1'b1);
         drv1(1'b1, 1'b1, 20'h00300 + 20'(i), d, 16'hFFFF, 1'(i == 3));
         #1;
         chkb("bl_p1_ready", p1_req_ready, 1'b1);
         chkb("bl_p0_ready", p0_req_ready, 1'b0);
         chkw("bl_mem_addr", 128'(mem_addr), 128'h300 + 128'(i));
         chkw("bl_mem_we",   128'(mem_we), 128'hFFFF);
         chkw("bl_mem_din",  mem_din, d);
         chkb("bl_p0_rsp",   p0_rsp_valid, 1'(i == 0));
      end
      @(negedge clk); drv1(1'b0, 1'b0, 20'h0, 128'h0, 16'h0, 1'b1); #1;
      chkb("bl_post_p0_ready", p0_req_ready, 1'b1);
      chkw("bl_post_mem_addr", 128'(mem_addr), 128'h10);

      // starvation bound: p0 endless burst of empty-strobe writes
      @(negedge clk);
      drv0(1'b1, 1'b1, 20'h00400, 128'h0, 16'h0000, 1'b0);
      drv1(1'b0, 1'b0, 20'h0, 128'h0, 16'h0, 1'b1);
      #1;
      chkb("sv_c1_p0_ready", p0_req_ready, 1'b1);
      chkb("sv_wstrb0_en",   mem_en,       1'b1);
      chkw("sv_wstrb0_we",   128'(mem_we), 128'h0);
      chkb("sv_c1_p0_rsp",   p0_rsp_valid, 1'b1);
      for (int c = 2; c <= 16; c++) begin
         @(negedge clk); drv1(1'b1, 1'b0, 20'h00010, 128'h0, 16'h0, 1'b1); #1;
         chkb("sv_lock_p0_ready", p0_req_ready, 1'b1);
         chkb("sv_lock_p1_ready", p1_req_ready, 1'b0);
      end
      @(negedge clk); #1;
      chkb("sv_c17_p1_ready", p1_req_ready, 1'b1);
      chkb("sv_c17_p0_ready", p0_req_ready, 1'b0);
      chkw("sv_c17_mem_addr", 128'(mem_addr), 128'h10);
      @(negedge clk); #1;
      chkb("sv_c18_p0_ready", p0_req_ready, 1'b1);
      chkb("sv_c18_p1_ready", p1_req_ready, 1'b0);
      chkb("sv_c18_p1_rsp",   p1_rsp_valid, 1'b1);
      chkw("sv_c18_p1_data",  p1_rsp_rdata, PRE0);
      @(negedge clk); drv0(1'b1, 1'b1, 20'h00400, 128'h0, 16'h0000, 1'b1); #1;
      chkb("sv_c19_p0_ready", p0_req_ready, 1'b1);

      // partial write then read-back
      @(negedge clk);
      drv0(1'b0, 1'b0, 20'h0, 128'h0, 16'h0, 1'b1);
      drv1(1'b1, 1'b1, 20'h1FFFF, 128'h0000000000000000DEADBEEF00000000, 16'h00F0, 1'b1);
      #1;
      chkb("pw_p1_ready", p1_req_ready, 1'b1);
      chkw("pw_mem_we",   128'(mem_we), 128'h00F0);
      chkw("pw_mem_addr", 128'(mem_addr), 128'h1FFFF);
      chkw("pw_mem_din",  mem_din, 128'h0000000000000000DEADBEEF00000000);
      @(negedge clk); drv1(1'b1, 1'b0, 20'h1FFFF, 128'h0, 16'h0, 1'b1); #1;
      chkb("pw_rd_p1_ready", p1_req_ready, 1'b1);
      @(negedge clk); idle(); #1;
      chkb("pw_rd_p1_rsp",  p1_rsp_valid, 1'b1);
      chkw("pw_rd_p1_data", p1_rsp_rdata, 128'h0011223344556677DEADBEEFCCDDEEFF);

      // reset during the third beat of a p0 read burst
      @(negedge clk); drv0(1'b1, 1'b0, 20'h00010, 128'h0, 16'h0, 1'b0); #1;
      chkb("rm_b1_p0_ready", p0_req_ready, 1'b1);
      @(negedge clk); drv0(1'b1, 1'b0, 20'h00011, 128'h0, 16'h0, 1'b0); #1;
      chkb("rm_b2_p0_ready", p0_req_ready, 1'b1);
      chkb("rm_b2_p0_rsp",   p0_rsp_valid, 1'b1);
      @(negedge clk); drv0(1'b1, 1'b0, 20'h00012, 128'h0, 16'h0, 1'b0); rst = 1'b1; #1;
      chkb("rm_b3_p0_ready", p0_req_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      drv0(1'b0, 1'b0, 20'h0, 128'h0, 16'h0, 1'b1);
      drv1(1'b1, 1'b0, 20'h00010, 128'h0, 16'h0, 1'b1);
      #1;
      chkb("rm_p1_ready_now", p1_req_ready, 1'b1);
      chkb("rm_no_p0_rsp",    p0_rsp_valid, 1'b0);
      @(negedge clk); idle(); #1;
      chkb("rm_p0_rsp_quiet", p0_rsp_valid, 1'b0);
      chkb("rm_p1_rsp",       p1_rsp_valid, 1'b1);
      chkw("rm_p1_data",      p1_rsp_rdata, PRE0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
